// File: rtl/imm_enc_pkg.sv
// Shared opcodes, instruction field layout and encoder state set for imm_encoder.
package imm_enc_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned CONST_W = 16;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned REG_FW  = 3;
  localparam int unsigned IMM_W   = 6;

  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS_LSB  = 6;
  localparam int unsigned IMM_LSB = 0;

  // Constant bits that must all match for the single-word form (signed -32..31)
  localparam int unsigned SHORT_MSB = 15;
  localparam int unsigned SHORT_LSB = 5;
  localparam int unsigned SHORT_W   = SHORT_MSB - SHORT_LSB + 1;

  localparam logic [OP_W-1:0]   OP_ADDI   = 4'h4;
  localparam logic [OP_W-1:0]   OP_ORI    = 4'h6;
  localparam logic [OP_W-1:0]   OP_SLLI   = 4'h7;
  localparam logic [REG_FW-1:0] R0        = 3'd0;
  localparam logic [IMM_W-1:0]  SHIFT_AMT = 6'd6;

  typedef enum logic [2:0] {
    IDLE,
    HI,
    SH1,
    MID,
    SH2,
    LO
  } state_t;

  function automatic logic [INSTR_W-1:0] enc(
    input logic [OP_W-1:0]   op,
    input logic [REG_FW-1:0] rd,
    input logic [REG_FW-1:0] rs,
    input logic [IMM_W-1:0]  imm
  );
    logic [INSTR_W-1:0] w;
    w = '0;
    w[OP_LSB  +: OP_W]   = op;
    w[RD_LSB  +: REG_FW] = rd;
    w[RS_LSB  +: REG_FW] = rs;
    w[IMM_LSB +: IMM_W]  = imm;
    return w;
  endfunction

endpackage

// File: rtl/imm_range_chk.sv
// Flags constants whose upper bits are a pure sign extension (fits one ADDI).
// Only present when IMM_ENCODER_SHORT_EN is defined.
`ifdef IMM_ENCODER_SHORT_EN
module imm_range_chk
  import imm_enc_pkg::*;
(
  input  logic [SHORT_W-1:0] hi_bits,
  output logic               fit_c
);

  assign fit_c = (&hi_bits) | ~(|hi_bits);

endmodule
`endif

// File: rtl/imm_encoder.sv
// Expands a 16-bit constant into an ADDI/SLLI/ORI instruction sequence.
// Define IMM_ENCODER_SHORT_EN to emit a single ADDI for constants in -32..31.
module imm_encoder #(
  parameter int unsigned RD_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     in_const,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     out_instr,
  output logic            out_last
);

  import imm_enc_pkg::*;

  state_t             state;
  state_t             nxt_c;
  logic [CONST_W-1:0] c_q;
  logic [RD_W-1:0]    rd_q;

`ifdef IMM_ENCODER_SHORT_EN
  logic fit_c;
  logic short_q;

  imm_range_chk u_range_chk (
    .hi_bits (in_const[SHORT_MSB:SHORT_LSB]),
    .fit_c   (fit_c)
  );
`else
  logic fit_c;
  logic short_q;

  assign fit_c   = 1'b0;
  assign short_q = 1'b0;
`endif

  // Instruction word shown while sitting in state s
  function automatic logic [INSTR_W-1:0] word_of(
    input state_t             s,
    input logic [CONST_W-1:0] c,
    input logic [REG_FW-1:0]  rd,
    input logic               short_f
  );
    case (s)
      HI:       return enc(OP_ADDI, rd, R0, {2'b00, c[15:12]});
      SH1, SH2: return enc(OP_SLLI, rd, rd, SHIFT_AMT);
      MID:      return enc(OP_ORI, rd, rd, c[11:6]);
      LO:       return short_f ? enc(OP_ADDI, rd, R0, c[5:0])
                               : enc(OP_ORI, rd, rd, c[5:0]);
      default:  return '0;
    endcase
  endfunction

  function automatic state_t next_of(input state_t s);
    case (s)
      HI:      return SH1;
      SH1:     return MID;
      MID:     return SH2;
      SH2:     return LO;
      default: return IDLE;
    endcase
  endfunction

  always_comb begin
    nxt_c = next_of(state);
  end

  // Sequencer: every output is loaded together with the state it describes
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_instr <= '0;
      c_q       <= '0;
      rd_q      <= '0;
`ifdef IMM_ENCODER_SHORT_EN
      short_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            c_q       <= in_const;
            rd_q      <= in_rd;
            state     <= fit_c ? LO : HI;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            out_last  <= fit_c;
            out_instr <= word_of(fit_c ? LO : HI, in_const, REG_FW'(in_rd), fit_c);
`ifdef IMM_ENCODER_SHORT_EN
            short_q   <= fit_c;
`endif
          end
        end
        default: begin
          if (out_ready) begin
            state <= nxt_c;
            if (nxt_c == IDLE) begin
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_instr <= '0;
            end else begin
              out_last  <= (nxt_c == LO);
              out_instr <= word_of(nxt_c, c_q, REG_FW'(rd_q), short_q);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: ISA-level model plus directed literal vectors.
module tb_imm_encoder;

`ifdef IMM_ENCODER_SHORT_EN
  localparam bit SHORT_EN = 1'b1;
`else
  localparam bit SHORT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_const;
  logic [2:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic        out_last;

  always #5 clk = ~clk;

  imm_encoder #(.RD_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_const  (in_const),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_last  (out_last)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_w [$];
  logic        exp_l [$];
  logic [15:0] cst_q [$];
  logic [15:0] got   [$];
  logic [15:0] acc       = 16'h0;
  bit          post_last = 1'b0;
  bit          hold_v    = 1'b0;
  logic [15:0] hold_i    = 16'h0;
  logic        hold_l    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit fits_short(input logic [15:0] c);
    int v;
    v = int'($signed(c));
    return SHORT_EN && (v >= -32) && (v <= 31);
  endfunction

  // Expected word list for one constant
  task automatic model_push(input logic [15:0] c, input logic [2:0] rd);
    if (fits_short(c)) begin
      exp_w.push_back({4'h4, rd, 3'd0, c[5:0]});            exp_l.push_back(1'b1);
    end else begin
      exp_w.push_back({4'h4, rd, 3'd0, 2'b00, c[15:12]});   exp_l.push_back(1'b0);
      exp_w.push_back({4'h7, rd, rd, 6'd6});                exp_l.push_back(1'b0);
      exp_w.push_back({4'h6, rd, rd, c[11:6]});             exp_l.push_back(1'b0);
      exp_w.push_back({4'h7, rd, rd, 6'd6});                exp_l.push_back(1'b0);
      exp_w.push_back({4'h6, rd, rd, c[5:0]});              exp_l.push_back(1'b1);
    end
    cst_q.push_back(c);
  endtask

  // Executes one word on the destination register value
  function automatic logic [15:0] exec(input logic [15:0] a, input logic [15:0] w);
    logic [5:0] imm;
    imm = w[5:0];
    case (w[15:12])
      4'h4:    return {{10{imm[5]}}, imm};
      4'h6:    return a | {10'd0, imm};
      4'h7:    return a << imm;
      default: return 16'hDEAD;
    endcase
  endfunction

  // Compare process: inputs change at posedge+1, so negedge sees settled values
  always @(negedge clk) begin
    if (rst) begin
      exp_w.delete(); exp_l.delete(); cst_q.delete();
      acc = 16'h0; post_last = 1'b0; hold_v = 1'b0;
    end else begin
      if (post_last) begin
        chk("idle_after_last_valid", 32'(out_valid), 32'(0));
        chk("idle_after_last_ready", 32'(in_ready), 32'(1));
      end
      post_last = 1'b0;
      chk("ready_vs_valid", 32'(in_ready), 32'(!out_valid));
      if (hold_v) begin
        chk("hold_valid", 32'(out_valid), 32'(1));
        chk("hold_instr", 32'(out_instr), 32'(hold_i));
        chk("hold_last", 32'(out_last), 32'(hold_l));
      end
      hold_v = out_valid && !out_ready;
      hold_i = out_instr;
      hold_l = out_last;
      if (out_valid && out_ready) begin
        if (exp_w.size() == 0) begin
          chk("unexpected_word", 32'(out_instr), 32'hFFFF_FFFF);
        end else begin
          chk("word", 32'(out_instr), 32'(exp_w.pop_front()));
          chk("last", 32'(out_last), 32'(exp_l.pop_front()));
        end
        got.push_back(out_instr);
        acc = exec(acc, out_instr);
        if (out_last) begin
          if (cst_q.size() != 0) chk("reproduce", 32'(acc), 32'(cst_q.pop_front()));
          acc = 16'h0;
          post_last = 1'b1;
        end
      end
      if (in_valid && in_ready) model_push(in_const, in_rd);
    end
  end

  task automatic send(input logic [15:0] c, input logic [2:0] rd);
    in_valid = 1'b1; in_const = c; in_rd = rd;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      if (!out_valid && in_ready && exp_w.size() == 0) done = 1'b1;
    end
    out_ready = 1'b1;
    chk("idle_timeout", 32'(done), 32'(1));
  endtask

  task automatic wait_got(input int n);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (got.size() >= n) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("got_timeout", 32'(done), 32'(1));
  endtask

  task automatic check_got(input string name, input int n,
                           input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                           input logic [15:0] w3, input logic [15:0] w4);
    logic [15:0] lit [5];
    lit[0] = w0; lit[1] = w1; lit[2] = w2; lit[3] = w3; lit[4] = w4;
    chk({name, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      chk($sformatf("%s_w%0d", name, i), 32'(got[i]), 32'(lit[i]));
  endtask

  task automatic run_one(input logic [15:0] c, input logic [2:0] rd);
    got.delete();
    send(c, rd);
    wait_idle(60, 1'b0);
  endtask

  logic [15:0] bvals [8];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_const = '0; in_rd = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_last", 32'(out_last), 32'(0));
    chk("rst_out_instr", 32'(out_instr), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;

    run_one(16'h1234, 3'd2);
    check_got("c1234", 5, 16'h4401, 16'h7486, 16'h6488, 16'h7486, 16'h64B4);

    // Back-pressure on the second word
    got.delete();
    send(16'h1234, 3'd2);
    wait_got(1);
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stall_word", 32'(out_instr), 32'h7486);
    out_ready = 1'b1;
    wait_idle(60, 1'b0);
    check_got("stall", 5, 16'h4401, 16'h7486, 16'h6488, 16'h7486, 16'h64B4);

    // Reset while MID is showing
    got.delete();
    send(16'h1234, 3'd5);
    wait_got(2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("abort_out_valid", 32'(out_valid), 32'(0));
    chk("abort_in_ready", 32'(in_ready), 32'(1));
    chk("abort_words", 32'(got.size()), 32'(2));
    @(posedge clk); #1;
    run_one(16'h00FF, 3'd7);
    check_got("c00ff", 5, 16'h4E00, 16'h7FC6, 16'h6FC3, 16'h7FC6, 16'h6FFF);

    // Reset beats a simultaneous request
    got.delete();
    rst = 1'b1; in_valid = 1'b1; in_const = 16'h1234; in_rd = 3'd1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk); #1;
    chk("rst_prio_valid", 32'(out_valid), 32'(0));
    chk("rst_prio_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;

    // Requests while busy are ignored
    got.delete();
    send(16'h0ABC, 3'd4);
    in_valid = 1'b1; in_const = 16'hAAAA; in_rd = 3'd1;
    wait_got(4);
    in_valid = 1'b0;
    wait_idle(60, 1'b0);
    chk("busy_words", 32'(got.size()), 32'(5));

`ifdef IMM_ENCODER_SHORT_EN
    run_one(16'h001F, 3'd3);
    check_got("c001f", 1, 16'h461F, 16'h0, 16'h0, 16'h0, 16'h0);
    run_one(16'hFFE0, 3'd1);
    check_got("cffe0", 1, 16'h4220, 16'h0, 16'h0, 16'h0, 16'h0);
    run_one(16'h0005, 3'd0);
    check_got("c0005", 1, 16'h4005, 16'h0, 16'h0, 16'h0, 16'h0);
`else
    run_one(16'h001F, 3'd3);
    check_got("c001f", 5, 16'h4600, 16'h76C6, 16'h66C0, 16'h76C6, 16'h66DF);
    run_one(16'hFFE0, 3'd1);
    check_got("cffe0", 5, 16'h420F, 16'h7246, 16'h627F, 16'h7246, 16'h6260);
    run_one(16'h0005, 3'd0);
    check_got("c0005", 5, 16'h4000, 16'h7006, 16'h6000, 16'h7006, 16'h6005);
`endif

    // Range boundaries under random back-pressure
    bvals[0] = 16'h0000; bvals[1] = 16'hFFFF; bvals[2] = 16'h001F; bvals[3] = 16'h0020;
    bvals[4] = 16'hFFE0; bvals[5] = 16'hFFDF; bvals[6] = 16'h7FFF; bvals[7] = 16'h8000;
    for (int i = 0; i < 8; i++) begin
      got.delete();
      send(bvals[i], 3'(i));
      wait_idle(200, 1'b1);
      chk($sformatf("bound%0d_count", i), 32'(got.size()), fits_short(bvals[i]) ? 32'd1 : 32'd5);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 The module SHALL expose parameter RD_W, default 3, register-index width.
REQ-002 The module SHALL expose port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 The module SHALL expose port rst  input  1  reset; one clock, synchronous, active-high.
REQ-004 The module SHALL expose port in_valid  input  1  request carries a constant.
REQ-005 The module SHALL expose port in_ready  output  1  encoder accepts a request.
REQ-006 The module SHALL expose port in_const  input  16  constant to be materialised.
REQ-007 The module SHALL expose port in_rd  input  RD_W  destination register index.
REQ-008 The module SHALL expose port out_valid  output  1  out_instr holds a valid instruction word.
REQ-009 The module SHALL expose port out_ready  input  1  consumer takes the word.
REQ-010 The module SHALL expose port out_instr  output  16  encoded instruction {op[15:12], rd[11:9], rs[8:6], imm6[5:0]}.
REQ-011 The module SHALL expose port out_last  output  1  current word is the final word for the constant.

Function
REQ-012 The encoder SHALL use the states IDLE, HI, SH1, MID, SH2 and LO.
REQ-013 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0; in all other states, in_ready SHALL be 0.
REQ-014 On in_valid&&in_ready, the encoder SHALL register in_const/in_rd and enter HI, or LO in short form, next cycle; out_valid SHALL be 1 from that cycle.
REQ-015 A word SHALL transfer on out_valid&&out_ready; out_instr and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-016 Long-form sequence, one state per word:
- HI: ADDI rd,r0,{2'b00,c[15:12]}
- SH1: SLLI rd,rd,6
- MID: ORI rd,rd,c[11:6]
- SH2: SLLI rd,rd,6
- LO: ORI rd,rd,c[5:0]
REQ-017 Short form SHALL apply when c[15:5] is all-0 or all-1, i.e. signed range -32..31; it SHALL emit a single word ADDI rd,r0,c[5:0] from state LO.
REQ-018 Each transfer SHALL advance HI→SH1→MID→SH2→LO; a transfer in LO SHALL return the encoder to IDLE.
REQ-019 out_last SHALL be 1 only in LO.
REQ-020 ADDI immediates SHALL be interpreted sign-extended and ORI immediates zero-extended, so the sequence reproduces c exactly.
REQ-021 Zero-valued chunks SHALL still be emitted, giving a fixed five-word length in long form.
REQ-022 After a last-word transfer, in_ready SHALL be 1 the following cycle, so there is one idle cycle minimum between constants.
REQ-023 While not IDLE, the encoder SHALL ignore in_valid, leaving captured values unchanged.

Reset
REQ-024 When rst=1 at a clock edge, the encoder SHALL enter IDLE with out_valid=0, out_last=0, out_instr=16'h0000 and captured registers cleared.
REQ-025 Reset mid-sequence SHALL abort the sequence with no further words; in_ready SHALL be 1 the cycle after rst deasserts.
REQ-026 Reset SHALL take priority over a simultaneous handshake.

Configuration
REQ-027 When macro IMM_ENCODER_SHORT_EN is defined, the encoder SHALL apply the short-form detection of REQ-017.
REQ-028 When IMM_ENCODER_SHORT_EN is undefined, the encoder SHALL always use the five-word long form; no detection logic SHALL remain.

Structure
REQ-029 Package imm_enc_pkg SHALL hold:
- opcodes OP_ADDI=4'h4, OP_ORI=4'h6, OP_SLLI=4'h7
- R0 index 0
- field bit positions
- state enumeration
REQ-030 One combinational sub-module imm_range_chk SHALL compute the short-form fit flag; the module SHALL instantiate it only under IMM_ENCODER_SHORT_EN.

Verification
REQ-031 With SHORT_EN, const 16'h001F, rd=3, out_ready=1 -> single word 16'h461F, out_last=1, in_ready=1 next cycle.
REQ-032 With SHORT_EN, const 16'hFFE0, rd=1 -> single word 16'h4220.
REQ-033 Const 16'h1234, rd=2 -> words 16'h4401, 16'h7486, 16'h6488, 16'h7486, 16'h64B4; out_last on the fifth word only.
REQ-034 Const 16'h1234 with out_ready=0 for 3 cycles at word 2 -> 16'h7486 held stable, no word skipped or repeated.
REQ-035 rst=1 during MID -> next cycle out_valid=0, in_ready=1; a new request then encodes normally.
REQ-036 Without SHORT_EN, const 16'h0005, rd=0 -> five words ending 16'h6005.
